// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared package for the bus transfer controller: FSM state encoding and phase constants.
// DATA_WIDTH falls back to 8 bits when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package bus_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } xfer_state_e;

    localparam int unsigned XFER_PHASES  = 4;
    localparam int unsigned XFER_LATENCY = 4;

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot select decoder with enable; output is all zero when disabled.
module reg_sel_decoder #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);

    // One-hot decode of sel, gated by en
    always_comb begin
        onehot = {NUM_REGS{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: rtl/tri_state_buffer.sv
// Generic tristate driver: places din on dout while en is high, otherwise releases the bus.
module tri_state_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] dout
);

    assign dout = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register / immediate-to-register transfer controller on a shared tristate bus.
// Four-phase sequence DRIVE -> LATCH -> HOLD -> IDLE; all strobes are registered.
module bus_xfer_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_REGS   = 8,
    parameter int SEL_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_src,
    input  logic [SEL_W-1:0]      req_dst,
    input  logic                  req_imm,
    input  logic [DATA_WIDTH-1:0] req_imm_data,
    output logic [NUM_REGS-1:0]   cs,
    output logic [NUM_REGS-1:0]   oe,
    output logic [NUM_REGS-1:0]   we,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  done,
    output logic                  err
);

    import bus_xfer_ctrl_pkg::*;

    xfer_state_e           state_r, state_s;
    logic [SEL_W-1:0]      src_r, src_s, dst_r, dst_s;
    logic                  imm_r, imm_s;
    logic [DATA_WIDTH-1:0] imm_data_r, imm_data_s;
    logic                  reject_s, active_s;
    logic [NUM_REGS-1:0]   src_oh_s, dst_oh_s;
    logic [NUM_REGS-1:0]   cs_r, oe_r, we_r;
    logic                  drive_r, done_r, err_r, ready_r;
    logic [DATA_WIDTH-1:0] xfer_data_r;

    function automatic logic idx_ok(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} < (SEL_W+1)'(NUM_REGS));
    endfunction

    // Next-state, request acceptance and transfer field capture
    always_comb begin
        state_s    = state_r;
        src_s      = src_r;
        dst_s      = dst_r;
        imm_s      = imm_r;
        imm_data_s = imm_data_r;
        reject_s   = !idx_ok(req_dst) ||
                     (!req_imm && (!idx_ok(req_src) || (req_src == req_dst)));
        case (state_r)
            ST_IDLE: begin
                if (req_valid && !reject_s) begin
                    state_s    = ST_DRIVE;
                    src_s      = req_src;
                    dst_s      = req_dst;
                    imm_s      = req_imm;
                    imm_data_s = req_imm_data;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: state_s = ST_LATCH;
            ST_LATCH: state_s = ST_HOLD;
            ST_HOLD:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        active_s = (state_s != ST_IDLE);
    end

    // Strobes are decoded from the upcoming state so the registered outputs line up with it
    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_src_dec (
        .en     (active_s && !imm_s),
        .sel    (src_s),
        .onehot (src_oh_s)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dst_dec (
        .en     (active_s),
        .sel    (dst_s),
        .onehot (dst_oh_s)
    );

    // State, transfer fields and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            src_r       <= {SEL_W{1'b0}};
            dst_r       <= {SEL_W{1'b0}};
            imm_r       <= 1'b0;
            imm_data_r  <= {DATA_WIDTH{1'b0}};
            cs_r        <= {NUM_REGS{1'b0}};
            oe_r        <= {NUM_REGS{1'b0}};
            we_r        <= {NUM_REGS{1'b0}};
            drive_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ready_r     <= 1'b1;
            xfer_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            src_r      <= src_s;
            dst_r      <= dst_s;
            imm_r      <= imm_s;
            imm_data_r <= imm_data_s;
            cs_r       <= src_oh_s | dst_oh_s;
            oe_r       <= src_oh_s;
            we_r       <= (state_s == ST_LATCH) ? dst_oh_s : {NUM_REGS{1'b0}};
            drive_r    <= active_s && imm_s;
            done_r     <= (state_r == ST_HOLD);
            err_r      <= (state_r == ST_IDLE) && req_valid && reject_s;
            ready_r    <= (state_s == ST_IDLE);
            if (state_r == ST_LATCH) begin
                xfer_data_r <= data;
            end
        end
    end

    tri_state_buffer #(.WIDTH(DATA_WIDTH)) u_imm_drv (
        .en   (drive_r),
        .din  (imm_data_r),
        .dout (data)
    );

    assign req_ready = ready_r;
    assign cs        = cs_r;
    assign oe        = oe_r;
    assign we        = we_r;
    assign done      = done_r;
    assign err       = err_r;
    assign xfer_data = xfer_data_r;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: eight modelled bus registers, scoreboard of
// expected completions/rejections, per-cycle strobe sanity checks.
module tb_bus_xfer_ctrl;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_src = 3'd0;
    logic [SW-1:0] req_dst = 3'd0;
    logic          req_imm = 1'b0;
    logic [DW-1:0] req_imm_data = 8'h00;
    logic [NR-1:0] cs, oe, we;
    wire  [DW-1:0] data;
    logic [DW-1:0] xfer_data;
    logic          done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] val;
        int         dst;
        int         cyc;
    } exp_t;

    exp_t       done_q[$];
    int         err_q[$];
    logic [7:0] init_val [NR];
    logic [7:0] model    [NR];
    logic [7:0] regs     [NR];
    logic       load_regs = 1'b1;
    logic       tb_en;
    logic [7:0] tb_drv;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_imm      (req_imm),
        .req_imm_data (req_imm_data),
        .cs           (cs),
        .oe           (oe),
        .we           (we),
        .data         (data),
        .xfer_data    (xfer_data),
        .done         (done),
        .err          (err)
    );

    // Bus register models: drive on OE, capture on CS&WE at the clock edge
    always_comb begin
        tb_en  = |oe;
        tb_drv = 8'h00;
        for (int i = 0; i < NR; i++) begin
            if (oe[i]) tb_drv = regs[i];
        end
    end
    assign data = tb_en ? tb_drv : 8'bzzzzzzzz;

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup (data[g]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NR; i++) begin
            if (load_regs) regs[i] <= init_val[i];
            else if (cs[i] && we[i]) regs[i] <= data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and per-cycle strobe checks
    always @(negedge clk) begin
        if (reset) begin
            check("oe_onehot0", 32'($onehot0(oe)), 32'd1);
            check("we_onehot0", 32'($onehot0(we)), 32'd1);
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    check("done_latency", 32'(cyc - e.cyc), 32'd4);
                    check("xfer_data", 32'(xfer_data), 32'(e.val));
                    check("dst_reg", 32'(regs[e.dst]), 32'(e.val));
                end
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    check("err_unexpected", 32'd1, 32'd0);
                end else begin
                    int c;
                    c = err_q.pop_front();
                    check("err_latency", 32'(cyc - c), 32'd1);
                end
            end
        end
    end

    // Present a request (called just after a rising edge) and return after the accepting edge
    task automatic issue(input int src, input int dst, input logic imm,
                         input logic [7:0] imm_data, output int acc_cyc);
        logic got;
        logic [7:0] val;
        logic [2:0] s3, d3;
        s3 = 3'(src);
        d3 = 3'(dst);
        got = 1'b0;
        acc_cyc = -1;
        req_valid = 1'b1;
        req_src = s3;
        req_dst = d3;
        req_imm = imm;
        req_imm_data = imm_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("issue_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            if (!imm && s3 == d3) begin
                err_q.push_back(cyc);
            end else begin
                val = imm ? imm_data : model[s3];
                model[d3] = val;
                done_q.push_back('{val: val, dst: dst, cyc: cyc});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2;
        logic [7:0] saved;
        for (int i = 0; i < NR; i++) begin
            init_val[i] = 8'(i * 17 + 3);
        end
        init_val[2] = 8'h5A;
        for (int i = 0; i < NR; i++) model[i] = init_val[i];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_xfer_data", 32'(xfer_data), 32'd0);
        check("rst_bus_hiz", 32'(data), 32'hFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        load_regs = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Register move 2 -> 5
        issue(2, 5, 1'b0, 8'h00, a1);
        idle(6);

        // Immediate 0xC3 -> reg0: no OE, bus driven through HOLD, released afterwards
        issue(0, 0, 1'b1, 8'hC3, a1);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("imm_oe_zero", 32'(oe), 32'd0);
            if (k < 3) check("imm_bus_drive", 32'(data), 32'hC3);
            else       check("imm_bus_hiz", 32'(data), 32'hFF);
        end
        idle(3);

        // Reject src == dst
        issue(3, 3, 1'b0, 8'h00, a1);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rej_no_cs", 32'(cs), 32'd0);
            check("rej_ready", 32'(req_ready), 32'd1);
        end
        idle(2);

        // Back-to-back 2 -> 5 then 5 -> 7 with req_valid held
        issue(2, 5, 1'b0, 8'h00, a1);
        issue(5, 7, 1'b0, 8'h00, a2);
        check("b2b_spacing", 32'(a2 - a1), 32'd4);
        idle(6);
        check("b2b_reg7", 32'(regs[7]), 32'h5A);

        // Reset asserted during LATCH abandons the transfer
        saved = model[4];
        issue(1, 4, 1'b0, 8'h00, a1);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("latch_we", 32'(we), 32'h10);
        check("latch_cs", 32'(cs), 32'h12);
        reset = 1'b0;
        #1;
        check("arst_cs", 32'(cs), 32'd0);
        check("arst_oe", 32'(oe), 32'd0);
        check("arst_we", 32'(we), 32'd0);
        done_q.delete();
        model[4] = saved;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        check("arst_reg4_kept", 32'(regs[4]), 32'(saved));

        // Normal transfer after the abandoned one
        issue(6, 1, 1'b0, 8'h00, a1);
        idle(6);
        check("post_rst_reg1", 32'(regs[1]), 32'(init_val[6]));

        check("sb_empty", 32'(done_q.size() + err_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
